// File: rtl/prime_sweep_pkg.sv
// Shared types and constants for the prime sweep driver and the prime-checker side.
// Handshake bit positions are shared so both ends agree on any packed Go/over bundle.
package prime_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT,
    NEXT,
    FIN
  } sweep_state_t;

  localparam int WIDTH_DEFAULT   = 16;
  localparam int TIMEOUT_DEFAULT = 1023;
  localparam int FIRST_PRIME     = 2;

  localparam int HS_GO_BIT      = 0;
  localparam int HS_OVER_BIT    = 1;
  localparam int HS_ISPRIME_BIT = 2;
  localparam int HS_BITS        = 3;

endpackage

// File: rtl/prime_sweep_driver_out_hold.sv
// Valid/ready holding register for one prime: loaded by the sweep FSM, held until accepted.
module prime_out_hold #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_fire
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_fire;

  assign w_fire = r_valid & i_ready;

  // Data is only written on load, so it stays stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (w_fire) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_fire  = w_fire;

endmodule

// File: rtl/prime_sweep_driver.sv
// Sweeps candidates lo..hi, launches one prime check per candidate over the Go/over
// handshake and streams every prime found through a valid/ready output port.
module prime_sweep_driver
  import prime_sweep_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] prime_cnt,
  output logic             chk_go,
  output logic [WIDTH-1:0] chk_n,
  input  logic             chk_over,
  input  logic             chk_isprime,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0]    TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] FIRST_CAND = WIDTH'(FIRST_PRIME);

  sweep_state_t     r_state;
  sweep_state_t     w_stateNext;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] w_candNext;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_chkN;
  logic [WIDTH-1:0] r_cnt;
  logic [TW-1:0]    r_tmo;
  logic             r_err;
  logic [WIDTH-1:0] w_startCand;
  logic             w_accept;
  logic             w_load;
  logic             w_timeout;
  logic             w_fire;

  assign w_startCand = (lo < FIRST_CAND) ? FIRST_CAND : lo;
  assign w_accept    = (r_state == IDLE) && start;

  always_comb begin
    w_stateNext = r_state;
    w_candNext  = r_cand;
    w_load      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_candNext  = w_startCand;
          w_stateNext = (w_startCand > hi) ? FIN : ISSUE;
        end
      end
      ISSUE: w_stateNext = WAIT;
      WAIT: begin
        if (chk_over) begin
          w_load      = chk_isprime;
          w_stateNext = chk_isprime ? EMIT : NEXT;
        end else if (r_tmo == TMO_LAST) begin
          w_timeout   = 1'b1;
          w_stateNext = FIN;
        end
      end
      EMIT: begin
        if (w_fire) begin
          w_stateNext = NEXT;
        end
      end
      // The all-ones check stops the sweep instead of wrapping back to zero.
      NEXT: begin
        if ((r_cand == r_hi) || (r_cand == '1)) begin
          w_stateNext = FIN;
        end else begin
          w_candNext  = r_cand + 1'b1;
          w_stateNext = ISSUE;
        end
      end
      FIN:     w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cand  <= '0;
      r_hi    <= '0;
      r_chkN  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cand  <= w_candNext;
      if (w_accept) begin
        r_hi <= hi;
      end
      if (w_stateNext == ISSUE) begin
        r_chkN <= w_candNext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (r_state == ISSUE) begin
      r_tmo <= '0;
    end else if (r_state == WAIT) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  // err is sticky until the next accepted start; prime_cnt saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_fire && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  prime_out_hold #(
    .WIDTH(WIDTH)
  ) u_out_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_data (r_cand),
    .i_ready(out_ready),
    .o_valid(out_valid),
    .o_data (out_data),
    .o_fire (w_fire)
  );

  assign busy      = (r_state != IDLE) && (r_state != FIN);
  assign done      = (r_state == FIN);
  assign chk_go    = (r_state == ISSUE);
  assign chk_n     = r_chkN;
  assign err       = r_err;
  assign prime_cnt = r_cnt;

endmodule
